// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer: FIFO-buffered DAC pacer releasing one attenuated, rounded, saturated sample per tick.
// Optional DAC_PACER_UFLOW_CNT_EN adds a saturating 16-bit underflow counter port uflow_cnt.
module dac_sample_pacer #(
   parameter int DATA_WIDTH = 32,
   parameter int DAC_W      = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic                          enable,
   input  logic [DIV_W-1:0]              div_ratio,
   input  logic [2:0]                    atten,
   output logic [DAC_W-1:0]              dac_data,
   output logic                          dac_strobe,
   output logic                          underflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef DAC_PACER_UFLOW_CNT_EN
   ,
   output logic [15:0]                   uflow_cnt
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [DATA_WIDTH-1:0]        r_mem [FIFO_DEPTH];
   logic [AW-1:0]                r_wptr, r_rptr;
   logic [AW:0]                  r_level;
   logic [DIV_W-1:0]             r_cnt;
   logic [DAC_W-1:0]             r_dac;
   logic                         r_strobe, r_uflow;
   logic                         w_full, w_empty, w_push, w_pop, w_tick, w_unused;
   logic signed [DATA_WIDTH-1:0] w_y;
   logic [DAC_W:0]               w_r;
   logic [DAC_W-1:0]             w_fmt;
   assign w_full        = r_level == (AW+1)'(FIFO_DEPTH);
   assign w_empty       = r_level == '0;
   assign s_axis_tready = !rst && !w_full;
   assign w_push        = s_axis_tvalid && s_axis_tready;
   assign w_tick        = enable && (r_cnt >= div_ratio);
   assign w_pop         = w_tick && !w_empty;
   // Round half up on the bit just below the DAC word; only positive results can overflow.
   assign w_y      = $signed(r_mem[r_rptr]) >>> atten;
   assign w_r      = {w_y[DATA_WIDTH-1], w_y[DATA_WIDTH-1 -: DAC_W]} + (DAC_W+1)'(w_y[DATA_WIDTH-1-DAC_W]);
   assign w_fmt    = (!w_r[DAC_W] && w_r[DAC_W-1]) ? {1'b0, {(DAC_W-1){1'b1}}} : w_r[DAC_W-1:0];
   assign w_unused = ^w_y[DATA_WIDTH-DAC_W-1:0];
   assign dac_data   = r_dac;
   assign dac_strobe = r_strobe;
   assign underflow  = r_uflow;
   assign fifo_level = r_level;
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= s_axis_tdata;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_level  <= '0;
         r_cnt    <= '0;
         r_dac    <= '0;
         r_strobe <= 1'b0;
         r_uflow  <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_level  <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
         r_cnt    <= (!enable || w_tick) ? '0 : r_cnt + 1'b1;
         r_dac    <= w_pop ? w_fmt : r_dac;
         r_strobe <= w_tick;
         r_uflow  <= w_tick && w_empty;
      end
   end
`ifdef DAC_PACER_UFLOW_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) uflow_cnt <= '0;
      else if (w_tick && w_empty && uflow_cnt != 16'hFFFF) uflow_cnt <= uflow_cnt + 1'b1;
   end
`endif
endmodule

// File: tb/tb_dac_sample_pacer.sv
// tb_dac_sample_pacer: directed self-checking bench for dac_sample_pacer.
module tb_dac_sample_pacer;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0, s_axis_tready;
   logic        enable = 1'b0;
   logic [15:0] div_ratio = '0;
   logic [2:0]  atten = '0;
   logic [15:0] dac_data;
   logic        dac_strobe, underflow;
   logic [3:0]  fifo_level;
`ifdef DAC_PACER_UFLOW_CNT_EN
   logic [15:0] uflow_cnt;
`endif
   int total = 0, bad = 0;
   int nxt = 1, glvl = 0;

   dac_sample_pacer dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .enable(enable), .div_ratio(div_ratio), .atten(atten),
      .dac_data(dac_data), .dac_strobe(dac_strobe), .underflow(underflow), .fifo_level(fifo_level)
`ifdef DAC_PACER_UFLOW_CNT_EN
      , .uflow_cnt(uflow_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b exp=0", s_axis_tready); end
      total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
      total++; if (dac_data !== 16'h0) begin bad++; $display("FAIL rst_dac got=%h exp=0000", dac_data); end
      total++; if (dac_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b exp=0", dac_strobe); end
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL rst_uflow got=%b exp=0", underflow); end
      rst = 1'b0;
      #1;
      total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_rel_tready got=%b exp=1", s_axis_tready); end
      @(negedge clk);
      total++; if (dac_strobe !== 1'b0) begin bad++; $display("FAIL rst_rel_strobe got=%b exp=0", dac_strobe); end
   endtask

   task automatic test_formatting;
      logic [31:0] v [7] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_8000, 32'h4000_0000,
                             32'h8000_0000, 32'hFFFF_8000, 32'h7FFF_FFFF};
      logic [2:0]  a [7] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd1};
      logic [15:0] e [7] = '{16'h7FFF, 16'h8000, 16'h0001, 16'h1000, 16'hE000, 16'h0000, 16'h4000};
      enable = 1'b0;
      div_ratio = 16'd0;
      for (int i = 0; i < 7; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata = v[i];
         @(negedge clk);
      end
      s_axis_tvalid = 1'b0;
      total++; if (fifo_level !== 4'd7) begin bad++; $display("FAIL fmt_fill_level got=%0d exp=7", fifo_level); end
      for (int i = 0; i < 7; i++) begin
         atten = a[i];
         enable = 1'b1;
         @(negedge clk);
         total++; if (dac_data !== e[i]) begin bad++; $display("FAIL fmt_%0d got=%h exp=%h", i, dac_data, e[i]); end
         total++; if (dac_strobe !== 1'b1 || underflow !== 1'b0) begin bad++; $display("FAIL fmt_strobe_%0d got=%b%b exp=10", i, dac_strobe, underflow); end
      end
      enable = 1'b0;
      atten = 3'd0;
      @(negedge clk);
      total++; if (dac_strobe !== 1'b0) begin bad++; $display("FAIL fmt_idle_strobe got=%b exp=0", dac_strobe); end
      total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL fmt_drain_level got=%0d exp=0", fifo_level); end
      total++; if (dac_data !== 16'h4000) begin bad++; $display("FAIL fmt_hold got=%h exp=4000", dac_data); end
   endtask

   task automatic test_pacing;
      int lvl = 0, acc = 0;
      bit tick, push, pop;
      nxt = 1;
      div_ratio = 16'd3;
      enable = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 32'(1 << 16);
      for (int i = 1; i <= 60; i++) begin
         tick = (i % 4) == 0;
         push = lvl < 8;
         pop = tick && lvl > 0;
         if (push) acc++;
         lvl = lvl + int'(push) - int'(pop);
         @(negedge clk);
         total++; if (dac_strobe !== tick) begin bad++; $display("FAIL pace_strobe cyc=%0d got=%b exp=%b", i, dac_strobe, tick); end
         if (pop) begin
            total++; if (dac_data !== 16'(nxt)) begin bad++; $display("FAIL pace_order cyc=%0d got=%h exp=%h", i, dac_data, 16'(nxt)); end
            nxt++;
         end
         total++; if (fifo_level !== 4'(lvl)) begin bad++; $display("FAIL pace_level cyc=%0d got=%0d exp=%0d", i, fifo_level, lvl); end
         total++; if (s_axis_tready !== (lvl < 8)) begin bad++; $display("FAIL pace_tready cyc=%0d got=%b exp=%b", i, s_axis_tready, lvl < 8); end
         s_axis_tdata = 32'((acc + 1) << 16);
      end
      enable = 1'b0;
      s_axis_tvalid = 1'b0;
      glvl = lvl;
   endtask

   task automatic test_underflow;
      div_ratio = 16'd0;
      enable = 1'b1;
      for (int i = 0; i < glvl + 4; i++) begin
         @(negedge clk);
         total++; if (dac_strobe !== 1'b1) begin bad++; $display("FAIL uf_strobe i=%0d got=%b exp=1", i, dac_strobe); end
         if (i < glvl) begin
            total++; if (dac_data !== 16'(nxt) || underflow !== 1'b0) begin bad++; $display("FAIL uf_drain i=%0d got=%h/%b exp=%h/0", i, dac_data, underflow, 16'(nxt)); end
            nxt++;
         end else begin
            total++; if (dac_data !== 16'(nxt - 1) || underflow !== 1'b1) begin bad++; $display("FAIL uf_empty i=%0d got=%h/%b exp=%h/1", i, dac_data, underflow, 16'(nxt - 1)); end
         end
      end
`ifdef DAC_PACER_UFLOW_CNT_EN
      total++; if (uflow_cnt !== 16'd4) begin bad++; $display("FAIL uf_cnt got=%0d exp=4", uflow_cnt); end
`endif
      enable = 1'b0;
      @(negedge clk);
      total++; if (dac_strobe !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL uf_stop got=%b%b exp=00", dac_strobe, underflow); end
      total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL uf_level got=%0d exp=0", fifo_level); end
   endtask

   task automatic test_enable_low;
      int acc = 0;
      bit any_strobe = 1'b0;
      enable = 1'b0;
      div_ratio = 16'd1;
      for (int i = 0; i < 20; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata = 32'((acc + 16) << 16);
         if (s_axis_tready) acc++;
         @(negedge clk);
         if (dac_strobe) any_strobe = 1'b1;
      end
      s_axis_tvalid = 1'b0;
      total++; if (acc != 8) begin bad++; $display("FAIL en_accepted got=%0d exp=8", acc); end
      total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL en_level got=%0d exp=8", fifo_level); end
      total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL en_tready got=%b exp=0", s_axis_tready); end
      total++; if (any_strobe) begin bad++; $display("FAIL en_no_strobe got=1 exp=0"); end
      enable = 1'b1;
      @(negedge clk);
      total++; if (dac_strobe !== 1'b0) begin bad++; $display("FAIL en_first_gap got=%b exp=0", dac_strobe); end
      @(negedge clk);
      total++; if (dac_strobe !== 1'b1 || dac_data !== 16'h0010) begin bad++; $display("FAIL en_first_strobe got=%b/%h exp=1/0010", dac_strobe, dac_data); end
      enable = 1'b0;
   endtask

   task automatic test_async_reset;
      div_ratio = 16'd0;
      enable = 1'b1;
      repeat (2) @(negedge clk);
      enable = 1'b0;
      total++; if (fifo_level !== 4'd5 || dac_data !== 16'h0012) begin bad++; $display("FAIL ar_pre got=%0d/%h exp=5/0012", fifo_level, dac_data); end
      div_ratio = 16'd2;
      enable = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 32'h0005_0000;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL ar_level got=%0d exp=0", fifo_level); end
      total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL ar_tready got=%b exp=0", s_axis_tready); end
      total++; if (dac_data !== 16'h0 || dac_strobe !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL ar_outs got=%h/%b/%b exp=0000/0/0", dac_data, dac_strobe, underflow); end
      @(negedge clk);
      rst = 1'b0;
      enable = 1'b0;
      s_axis_tvalid = 1'b0;
      #1;
      total++; if (s_axis_tready !== 1'b1 || fifo_level !== 4'd0) begin bad++; $display("FAIL ar_release got=%b/%0d exp=1/0", s_axis_tready, fifo_level); end
      repeat (3) begin
         @(negedge clk);
         total++; if (dac_strobe !== 1'b0) begin bad++; $display("FAIL ar_no_strobe got=%b exp=0", dac_strobe); end
      end
      div_ratio = 16'd0;
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      total++; if (dac_strobe !== 1'b1 || underflow !== 1'b1 || dac_data !== 16'h0) begin bad++; $display("FAIL ar_first_tick got=%b/%b/%h exp=1/1/0000", dac_strobe, underflow, dac_data); end
   endtask

   initial begin
      test_reset();
      test_formatting();
      test_pacing();
      test_underflow();
      test_enable_low();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
